// File: rtl/gpu_isa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : gpu_isa_pkg                                                |
// | Brief   : Opcode enumeration, decoded-control bundle and mux         |
// |           encodings shared by the decode stage.                      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package gpu_isa_pkg;

    // 4-bit opcode space; codes 10-14 are unassigned.
    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_BRNZP = 4'd1,
        OP_CMP   = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_MUL   = 4'd5,
        OP_DIV   = 4'd6,
        OP_LDR   = 4'd7,
        OP_STR   = 4'd8,
        OP_CONST = 4'd9,
        OP_RET   = 4'd15
    } opcode_e;

    // Register write-back source select.
    localparam logic [1:0] c_REG_IN_ALU   = 2'd0;
    localparam logic [1:0] c_REG_IN_MEM   = 2'd1;
    localparam logic [1:0] c_REG_IN_CONST = 2'd2;

    // ALU arithmetic operation select.
    localparam logic [1:0] c_ALU_ADD = 2'd0;
    localparam logic [1:0] c_ALU_SUB = 2'd1;
    localparam logic [1:0] c_ALU_MUL = 2'd2;
    localparam logic [1:0] c_ALU_DIV = 2'd3;

    // Decoded control bundle; an all-zero value is a NOP.
    typedef struct packed {
        logic       reg_we;
        logic       mem_re;
        logic       mem_we;
        logic       nzp_we;
        logic [1:0] reg_in_mux;
        logic [1:0] alu_arith_mux;
        logic       alu_out_mux;
        logic       pc_mux;
        logic       ret;
        logic       illegal;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/decode_logic.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : decode_logic                                               |
// | Brief   : Pure combinational opcode -> control bundle lookup.        |
// |           DECODE_ILLEGAL_TRAP_EN: opcodes 10-14 flag illegal,        |
// |           otherwise they decode as NOP.                              |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module decode_logic
    import gpu_isa_pkg::*;
(
    input  logic [3:0] i_opcode,
    output ctrl_t      o_ctrl
);

    // Opcode table lookup; every control not named for an opcode stays 0.
    always_comb begin
        o_ctrl = '0;
        case (i_opcode)
            OP_BRNZP: o_ctrl.pc_mux = 1'b1;
            OP_CMP: begin
                o_ctrl.alu_out_mux = 1'b1;
                o_ctrl.nzp_we      = 1'b1;
            end
            OP_ADD: begin
                o_ctrl.reg_we        = 1'b1;
                o_ctrl.reg_in_mux    = c_REG_IN_ALU;
                o_ctrl.alu_arith_mux = c_ALU_ADD;
            end
            OP_SUB: begin
                o_ctrl.reg_we        = 1'b1;
                o_ctrl.reg_in_mux    = c_REG_IN_ALU;
                o_ctrl.alu_arith_mux = c_ALU_SUB;
            end
            OP_MUL: begin
                o_ctrl.reg_we        = 1'b1;
                o_ctrl.reg_in_mux    = c_REG_IN_ALU;
                o_ctrl.alu_arith_mux = c_ALU_MUL;
            end
            OP_DIV: begin
                o_ctrl.reg_we        = 1'b1;
                o_ctrl.reg_in_mux    = c_REG_IN_ALU;
                o_ctrl.alu_arith_mux = c_ALU_DIV;
            end
            OP_LDR: begin
                o_ctrl.reg_we     = 1'b1;
                o_ctrl.mem_re     = 1'b1;
                o_ctrl.reg_in_mux = c_REG_IN_MEM;
            end
            OP_STR: o_ctrl.mem_we = 1'b1;
            OP_CONST: begin
                o_ctrl.reg_we     = 1'b1;
                o_ctrl.reg_in_mux = c_REG_IN_CONST;
            end
            OP_RET: o_ctrl.ret = 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
            4'd10, 4'd11, 4'd12, 4'd13, 4'd14: o_ctrl.illegal = 1'b1;
`endif
            default: o_ctrl = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/decode_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : decode_unit                                                |
// | Brief   : Instruction decode stage: combinational field/control      |
// |           decode into a 2-entry FIFO (head slot A, skid slot B)      |
// |           with a registered in_ready.                                |
// |           DECODE_ILLEGAL_TRAP_EN: enables the illegal-opcode flag    |
// |           and the sticky err_illegal output.                         |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module decode_unit
    import gpu_isa_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int CTX_W      = 2,
    localparam int INSTR_W   = 4 + 3*REG_ADDR_W,
    localparam int IMM_W     = 2*REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSTR_W-1:0]    in_instr,
    input  logic [CTX_W-1:0]      in_ctx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTX_W-1:0]      out_ctx,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [REG_ADDR_W-1:0] out_rs,
    output logic [REG_ADDR_W-1:0] out_rt,
    output logic [2:0]            out_nzp,
    output logic [IMM_W-1:0]      out_imm,
    output logic                  out_reg_we,
    output logic                  out_mem_re,
    output logic                  out_mem_we,
    output logic                  out_nzp_we,
    output logic [1:0]            out_reg_in_mux,
    output logic [1:0]            out_alu_arith_mux,
    output logic                  out_alu_out_mux,
    output logic                  out_pc_mux,
    output logic                  out_ret,
    output logic                  out_illegal,
    output logic                  err_illegal
);

    localparam int CTRL_W  = $bits(ctrl_t);
    localparam int ENTRY_W = CTX_W + 3*REG_ADDR_W + 3 + IMM_W + CTRL_W;

    // Occupancy states.
    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_FULL  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_in_ready;
    logic [ENTRY_W-1:0]    r_slot_a;
    logic [ENTRY_W-1:0]    r_slot_b;
    logic [ENTRY_W-1:0]    w_slot_a_nxt;
    logic [ENTRY_W-1:0]    w_slot_b_nxt;
    logic [ENTRY_W-1:0]    w_entry;
    logic [3:0]            w_opcode;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [REG_ADDR_W-1:0] w_rs;
    logic [REG_ADDR_W-1:0] w_rt;
    logic [2:0]            w_nzp;
    logic [IMM_W-1:0]      w_imm;
    ctrl_t                 w_ctrl;
    ctrl_t                 w_head_ctrl;
    logic                  w_push;
    logic                  w_pop;

    // Field extraction; imm overlaps rs/rt and nzp is the top of rd.
    assign w_opcode = in_instr[INSTR_W-1 -: 4];
    assign w_rd     = in_instr[3*REG_ADDR_W-1 -: REG_ADDR_W];
    assign w_rs     = in_instr[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign w_rt     = in_instr[REG_ADDR_W-1:0];
    assign w_imm    = in_instr[IMM_W-1:0];
    assign w_nzp    = w_rd[REG_ADDR_W-1 -: 3];

    decode_logic u_decode_logic (
        .i_opcode (w_opcode),
        .o_ctrl   (w_ctrl)
    );

    assign w_entry = {in_ctx, w_rd, w_rs, w_rt, w_nzp, w_imm, w_ctrl};

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != c_EMPTY);
    assign w_push    = in_valid & r_in_ready;
    assign w_pop     = out_valid & out_ready;

    // Slot A is always the head, so outputs come straight from its register.
    assign {out_ctx, out_rd, out_rs, out_rt, out_nzp, out_imm, w_head_ctrl} = r_slot_a;

    assign out_reg_we        = w_head_ctrl.reg_we;
    assign out_mem_re        = w_head_ctrl.mem_re;
    assign out_mem_we        = w_head_ctrl.mem_we;
    assign out_nzp_we        = w_head_ctrl.nzp_we;
    assign out_reg_in_mux    = w_head_ctrl.reg_in_mux;
    assign out_alu_arith_mux = w_head_ctrl.alu_arith_mux;
    assign out_alu_out_mux   = w_head_ctrl.alu_out_mux;
    assign out_pc_mux        = w_head_ctrl.pc_mux;
    assign out_ret           = w_head_ctrl.ret;
    assign out_illegal       = w_head_ctrl.illegal;

    // Occupancy next-state and slot movement; flush overrides any push/pop.
    always_comb begin
        w_state_nxt  = r_state;
        w_slot_a_nxt = r_slot_a;
        w_slot_b_nxt = r_slot_b;
        case (r_state)
            c_EMPTY: begin
                if (w_push) begin
                    w_state_nxt  = c_ONE;
                    w_slot_a_nxt = w_entry;
                end
            end
            c_ONE: begin
                if (w_push && w_pop) begin
                    w_slot_a_nxt = w_entry;
                end else if (w_push) begin
                    w_state_nxt  = c_FULL;
                    w_slot_b_nxt = w_entry;
                end else if (w_pop) begin
                    w_state_nxt  = c_EMPTY;
                end
            end
            c_FULL: begin
                // in_ready is low here, so only a pop can occur.
                if (w_pop) begin
                    w_state_nxt  = c_ONE;
                    w_slot_a_nxt = r_slot_b;
                end
            end
            default: w_state_nxt = c_EMPTY;
        endcase
        if (flush) begin
            w_state_nxt = c_EMPTY;
        end
    end

    // FIFO state register; in_ready is registered from the next occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_EMPTY;
            r_in_ready <= 1'b1;
            r_slot_a   <= '0;
            r_slot_b   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != c_FULL);
            r_slot_a   <= w_slot_a_nxt;
            r_slot_b   <= w_slot_b_nxt;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic r_err_illegal;

    // Sticky error: set when an illegal entry is consumed, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_illegal <= 1'b0;
        end else if (w_pop && w_head_ctrl.illegal) begin
            r_err_illegal <= 1'b1;
        end
    end

    assign err_illegal = r_err_illegal;
`else
    assign err_illegal = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_decode_unit                                             |
// | Brief   : Scoreboard bench for decode_unit: directed vectors push    |
// |           hand-computed expectations, a monitor checks every pop.    |
// |           Expectations follow DECODE_ILLEGAL_TRAP_EN when defined.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_decode_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = '0;
    logic [1:0]  in_ctx = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_ctx;
    logic [3:0]  out_rd, out_rs, out_rt;
    logic [2:0]  out_nzp;
    logic [7:0]  out_imm;
    logic        out_reg_we, out_mem_re, out_mem_we, out_nzp_we;
    logic [1:0]  out_reg_in_mux, out_alu_arith_mux;
    logic        out_alu_out_mux, out_pc_mux, out_ret, out_illegal, err_illegal;

    // Second instance with 5-bit register addresses (19-bit instructions).
    logic        flush5 = 1'b0;
    logic        in_valid5 = 1'b0;
    logic        in_ready5;
    logic [18:0] in_instr5 = '0;
    logic [1:0]  in_ctx5 = '0;
    logic        out_valid5;
    logic        out_ready5 = 1'b1;
    logic [1:0]  out_ctx5;
    logic [4:0]  out_rd5, out_rs5, out_rt5;
    logic [2:0]  out_nzp5;
    logic [9:0]  out_imm5;
    logic        out_reg_we5, out_mem_re5, out_mem_we5, out_nzp_we5;
    logic [1:0]  out_reg_in_mux5, out_alu_arith_mux5;
    logic        out_alu_out_mux5, out_pc_mux5, out_ret5, out_illegal5, err_illegal5;

    always #5 clk = ~clk;

    decode_unit u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_ctx(in_ctx),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctx(out_ctx),
        .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt), .out_nzp(out_nzp), .out_imm(out_imm),
        .out_reg_we(out_reg_we), .out_mem_re(out_mem_re), .out_mem_we(out_mem_we),
        .out_nzp_we(out_nzp_we), .out_reg_in_mux(out_reg_in_mux),
        .out_alu_arith_mux(out_alu_arith_mux), .out_alu_out_mux(out_alu_out_mux),
        .out_pc_mux(out_pc_mux), .out_ret(out_ret), .out_illegal(out_illegal),
        .err_illegal(err_illegal)
    );

    decode_unit #(.REG_ADDR_W(5), .CTX_W(2)) u_dut5 (
        .clk(clk), .reset(reset), .flush(flush5),
        .in_valid(in_valid5), .in_ready(in_ready5), .in_instr(in_instr5), .in_ctx(in_ctx5),
        .out_valid(out_valid5), .out_ready(out_ready5), .out_ctx(out_ctx5),
        .out_rd(out_rd5), .out_rs(out_rs5), .out_rt(out_rt5), .out_nzp(out_nzp5), .out_imm(out_imm5),
        .out_reg_we(out_reg_we5), .out_mem_re(out_mem_re5), .out_mem_we(out_mem_we5),
        .out_nzp_we(out_nzp_we5), .out_reg_in_mux(out_reg_in_mux5),
        .out_alu_arith_mux(out_alu_arith_mux5), .out_alu_out_mux(out_alu_out_mux5),
        .out_pc_mux(out_pc_mux5), .out_ret(out_ret5), .out_illegal(out_illegal5),
        .err_illegal(err_illegal5)
    );

    typedef struct packed {
        logic [1:0]  ctx;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [2:0]  nzp;
        logic [7:0]  imm;
        logic [11:0] ctl;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [11:0] act_ctl;
    assign act_ctl = {out_reg_we, out_mem_re, out_mem_we, out_nzp_we, out_reg_in_mux,
                      out_alu_arith_mux, out_alu_out_mux, out_pc_mux, out_ret, out_illegal};

    // Control word order: reg_we mem_re mem_we nzp_we reg_in[2] arith[2] alu_out pc ret illegal
    function automatic logic [11:0] cf(input logic we, mre, mwe, nwe, input logic [1:0] rin, ari,
                                       input logic aout, pc, rt, ill);
        return {we, mre, mwe, nwe, rin, ari, aout, pc, rt, ill};
    endfunction

    function automatic exp_t mk_exp(input logic [15:0] instr, input logic [1:0] ctx,
                                    input logic [11:0] ctl);
        exp_t e;
        e.ctx = ctx;
        e.rd  = instr[11:8];
        e.rs  = instr[7:4];
        e.rt  = instr[3:0];
        e.nzp = instr[11:9];
        e.imm = instr[7:0];
        e.ctl = ctl;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Offer one instruction; the expectation is queued at the accepting edge.
    task automatic send(input logic [15:0] instr, input logic [1:0] ctx, input logic [11:0] ctl);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_instr = instr;
        in_ctx   = ctx;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(mk_exp(instr, ctx, ctl));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 64'd0, 64'd1);
    endtask

    // Monitor: every handshake on the output side is checked against the queue head.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_output", {out_ctx, out_rd, out_imm}, 64'hFFFF_FFFF);
            end else begin
                mon_e = q.pop_front();
                chk("sb_entry", {out_ctx, out_rd, out_rs, out_rt, out_nzp, out_imm, act_ctl}, mon_e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [11:0] c_nop, c_add, c_const, c_ldr, c_ill;

    initial begin
        c_nop   = cf(0,0,0,0,2'd0,2'd0,0,0,0,0);
        c_add   = cf(1,0,0,0,2'd0,2'd0,0,0,0,0);
        c_const = cf(1,0,0,0,2'd2,2'd0,0,0,0,0);
        c_ldr   = cf(1,1,0,0,2'd1,2'd0,0,0,0,0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        c_ill   = cf(0,0,0,0,2'd0,2'd0,0,0,0,1);
`else
        c_ill   = c_nop;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_err", err_illegal, 0);
        chk("reset_fields", {out_ctx, out_rd, out_rs, out_rt, out_nzp, out_imm, act_ctl}, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // ADD r1,r2,r3: one-cycle latency
        send(16'h3123, 2'd1, c_add);
        chk("add_latency_valid", out_valid, 1);
        chk("add_fields", {out_rd, out_rs, out_rt}, 12'h123);
        chk("add_reg_we_arith", {out_reg_we, out_alu_arith_mux}, 3'b100);

        // Opcode table, back-to-back with out_ready=1
        send(16'h0123, 2'd0, c_nop);
        send(16'h2456, 2'd2, cf(0,0,0,1,2'd0,2'd0,1,0,0,0));
        send(16'h4321, 2'd3, cf(1,0,0,0,2'd0,2'd1,0,0,0,0));
        send(16'h5111, 2'd0, cf(1,0,0,0,2'd0,2'd2,0,0,0,0));
        send(16'h6222, 2'd1, cf(1,0,0,0,2'd0,2'd3,0,0,0,0));
        send(16'h8ABC, 2'd2, cf(0,0,1,0,2'd0,2'd0,0,0,0,0));
        send(16'h1E00, 2'd3, cf(0,0,0,0,2'd0,2'd0,0,1,0,0));
        chk("br_nzp", out_nzp, 3'b111);
        chk("br_pc_mux", out_pc_mux, 1);
        send(16'hF000, 2'd0, cf(0,0,0,0,2'd0,2'd0,0,0,1,0));
        chk("ret_flag", out_ret, 1);
        repeat (3) @(posedge clk); #1;

        // Backpressure: two accepted, third held, then drained in order
        out_ready = 1'b0;
        send(16'h9101, 2'd0, c_const);
        send(16'h9202, 2'd1, c_const);
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        fork
            send(16'h9303, 2'd2, c_const);
            begin
                repeat (3) @(negedge clk);
                chk("bp_still_blocked", in_ready, 0);
                chk("bp_head_stable", {out_rd, out_imm}, 12'h101);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk); #1;
        chk("bp_drained", out_valid, 0);

        // Simultaneous push and pop at occupancy 1
        out_ready = 1'b0;
        send(16'h3456, 2'd3, c_add);
        out_ready = 1'b1;
        send(16'h7A12, 2'd0, c_ldr);
        chk("pp_valid", out_valid, 1);
        chk("pp_ldr_ctl", {out_mem_re, out_reg_in_mux, out_rd}, {1'b1, 2'd1, 4'hA});
        @(posedge clk); #1;
        chk("pp_empty_after", out_valid, 0);

        // Flush at occupancy 2 with a concurrent offer
        out_ready = 1'b0;
        send(16'h9111, 2'd0, c_const);
        send(16'h9222, 2'd1, c_const);
        in_valid = 1'b1; in_instr = 16'h9333; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        q.delete();
        chk("flush_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);

        // Flush at occupancy 1 discards a same-cycle push
        send(16'h9444, 2'd2, c_const);
        in_valid = 1'b1; in_instr = 16'h9555; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        q.delete();
        chk("flush1_valid", out_valid, 0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("flush_nothing_kept", out_valid, 0);

        // Illegal opcode and sticky error
        send(16'hA000, 2'd1, c_ill);
        @(posedge clk); #1;
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("err_set", err_illegal, 1);
`else
        chk("err_set", err_illegal, 0);
`endif
        send(16'hE000, 2'd2, c_ill);
        send(16'h0000, 2'd3, c_nop);
        repeat (3) @(posedge clk); #1;
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("err_sticky", err_illegal, 1);
`else
        chk("err_sticky", err_illegal, 0);
`endif

        // Reset mid-stream dominates flush and a concurrent push
        out_ready = 1'b0;
        send(16'h9666, 2'd0, c_const);
        send(16'h9777, 2'd1, c_const);
        reset = 1'b1; flush = 1'b1; in_valid = 1'b1; in_instr = 16'h9888;
        @(posedge clk); #1;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        q.delete();
        chk("rst_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_err", err_illegal, 0);
        chk("rst_fields", {out_rd, out_imm, act_ctl}, 0);
        out_ready = 1'b1;

        // REG_ADDR_W=5 instance: ADD r1,r2,r3
        in_valid5 = 1'b1;
        in_instr5 = {4'h3, 5'd1, 5'd2, 5'd3};
        @(negedge clk);
        chk("w5_in_ready", in_ready5, 1);
        @(posedge clk); #1;
        in_valid5 = 1'b0;
        chk("w5_valid", out_valid5, 1);
        chk("w5_fields", {out_rd5, out_rs5, out_rt5}, {5'd1, 5'd2, 5'd3});
        chk("w5_ctl", {out_reg_we5, out_alu_arith_mux5}, 3'b100);

        // Final ADD after reset, then drain the scoreboard
        send(16'h3ABC, 2'd2, c_add);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #1;
        chk("sb_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
